// File: rtl/tt_sweep_capture.sv
// Truth-table capture: sweeps x through all 128 minterms, samples func_out after a settle delay
// and presents the assembled table on a valid/ready port. Optional TT_WEIGHT_EN adds a ones count.
module tt_sweep_capture #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned TT_BITS       = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic [6:0]         x,
    input  logic               func_out,
    output logic               busy,
    output logic [TT_BITS-1:0] tt,
    output logic               tt_valid,
    input  logic               tt_ready
`ifdef TT_WEIGHT_EN
    ,
    output logic [7:0]         tt_weight
`endif
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, RESULT} state_t;

    // With zero settle time every minterm goes straight to SAMPLE.
    localparam state_t     FIRST       = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
    localparam logic [7:0] SETTLE_LAST = 8'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    state_t     state;
    logic [6:0] idx;
    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            x         <= '0;
            tt        <= '0;
            tt_valid  <= 1'b0;
            busy      <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
`ifdef TT_WEIGHT_EN
            tt_weight <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    x <= '0;
                    if (start) begin
                        tt        <= '0;
                        idx       <= '0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        state     <= FIRST;
`ifdef TT_WEIGHT_EN
                        tt_weight <= '0;
`endif
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        state <= IDLE;
                        x     <= '0;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        state <= IDLE;
                        x     <= '0;
                        busy  <= 1'b0;
                    end else begin
                        tt[idx] <= func_out;
`ifdef TT_WEIGHT_EN
                        tt_weight <= tt_weight + {7'd0, func_out};
`endif
                        if (idx == 7'd127) begin
                            state    <= RESULT;
                            x        <= '0;
                            busy     <= 1'b0;
                            tt_valid <= 1'b1;
                        end else begin
                            idx   <= idx + 7'd1;
                            x     <= idx + 7'd1;
                            state <= FIRST;
                        end
                    end
                end
                RESULT: begin
                    x <= '0;
                    if (tt_ready) begin
                        tt_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Directed bench for tt_sweep_capture: one DUT at SETTLE_CYCLES=1 and one at SETTLE_CYCLES=0,
// each driving a behavioural function-under-test; checks tt_weight when TT_WEIGHT_EN is defined.
module tb_tt_sweep_capture;

    logic         clk = 1'b0;
    logic         rst = 1'b0;

    logic         start_a = 1'b0, abort_a = 1'b0, ready_a = 1'b0, func_a;
    logic [6:0]   x_a;
    logic         busy_a, valid_a;
    logic [127:0] tt_a;
    int           fsel_a = 0;

    logic         start_b = 1'b0, abort_b = 1'b0, ready_b = 1'b0, func_b;
    logic [6:0]   x_b;
    logic         busy_b, valid_b;
    logic [127:0] tt_b;
    int           fsel_b = 0;

`ifdef TT_WEIGHT_EN
    logic [7:0]   w_a, w_b;
`endif

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    // 0: x0, 1: x6, 2: AND of all inputs, 3: constant 0
    function automatic logic fval(input int sel, input logic [6:0] v);
        case (sel)
            0:       return v[0];
            1:       return v[6];
            2:       return &v;
            default: return 1'b0;
        endcase
    endfunction

    assign func_a = fval(fsel_a, x_a);
    assign func_b = fval(fsel_b, x_b);

    tt_sweep_capture #(.SETTLE_CYCLES(1)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .x(x_a),
        .func_out(func_a), .busy(busy_a), .tt(tt_a), .tt_valid(valid_a), .tt_ready(ready_a)
`ifdef TT_WEIGHT_EN
        , .tt_weight(w_a)
`endif
    );

    tt_sweep_capture #(.SETTLE_CYCLES(0)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .x(x_b),
        .func_out(func_b), .busy(busy_b), .tt(tt_b), .tt_valid(valid_b), .tt_ready(ready_b)
`ifdef TT_WEIGHT_EN
        , .tt_weight(w_b)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sweep on DUT A; optionally re-pulse start mid-sweep, which must be ignored.
    task automatic run_a(input int sel, input logic [127:0] exp_tt, input int exp_w, input bit poke);
        int n;
        fsel_a  = sel;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("a_busy_after_accept", 128'(busy_a), 128'd1);
        chk("a_x_after_accept", 128'(x_a), 128'd0);
        for (n = 1; n <= 1000; n++) begin
            start_a = (poke && n == 50);
            tick();
            if (valid_a) break;
        end
        start_a = 1'b0;
        chk("a_valid_latency", 128'(n), 128'd256);
        chk("a_tt", tt_a, exp_tt);
        chk("a_busy_in_result", 128'(busy_a), 128'd0);
`ifdef TT_WEIGHT_EN
        chk("a_weight", 128'(w_a), 128'(exp_w));
`else
        if (exp_w < 0) $display("unexpected weight argument");
`endif
    endtask

    task automatic run_b(input int sel, input logic [127:0] exp_tt, input int exp_w);
        int n;
        fsel_b  = sel;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (n = 1; n <= 1000; n++) begin
            tick();
            if (valid_b) break;
        end
        chk("b_valid_latency", 128'(n), 128'd128);
        chk("b_tt", tt_b, exp_tt);
`ifdef TT_WEIGHT_EN
        chk("b_weight", 128'(w_b), 128'(exp_w));
`else
        if (exp_w < 0) $display("unexpected weight argument");
`endif
        ready_b = 1'b1;
        tick();
        ready_b = 1'b0;
        chk("b_valid_after_ack", 128'(valid_b), 128'd0);
    endtask

    initial begin
        logic [127:0] tt_x0, tt_x6, tt_and;
        int           hits, n;
        tt_x0  = {32{4'hA}};
        tt_x6  = {{64{1'b1}}, {64{1'b0}}};
        tt_and = 128'd1 << 127;

        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("rst_x", 128'(x_a), 128'd0);
        chk("rst_busy", 128'(busy_a), 128'd0);
        chk("rst_tt", tt_a, 128'd0);
        chk("rst_valid", 128'(valid_a), 128'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // f = x0, then handshake immediately
        run_a(0, tt_x0, 64, 1'b0);
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        chk("x0_valid_after_ack", 128'(valid_a), 128'd0);
        chk("x0_tt_kept_after_ack", tt_a, tt_x0);

        // f = x6, consumer stalls for 10 cycles
        run_a(1, tt_x6, 64, 1'b0);
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid_a !== 1'b1 || tt_a !== tt_x6 || x_a !== 7'd0) hits++;
        end
        chk("x6_stall_unstable_cycles", 128'(hits), 128'd0);
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        chk("x6_valid_after_ack", 128'(valid_a), 128'd0);
        chk("x6_tt_kept_after_ack", tt_a, tt_x6);

        // Zero settle time: AND and constant-0
        run_b(2, tt_and, 1);
        run_b(3, 128'd0, 0);

        // start while busy, then start together with tt_ready in RESULT
        run_a(0, tt_x0, 64, 1'b1);
        start_a = 1'b1;
        ready_a = 1'b1;
        tick();
        start_a = 1'b0;
        ready_a = 1'b0;
        chk("start_in_result_valid", 128'(valid_a), 128'd0);
        chk("start_in_result_busy", 128'(busy_a), 128'd0);
        hits = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (busy_a || valid_a) hits++;
        end
        chk("no_second_sweep", 128'(hits), 128'd0);

        // abort at idx 40
        fsel_a  = 1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (n = 0; n < 200 && x_a !== 7'd40; n++) tick();
        chk("abort_reached_idx40", 128'(x_a), 128'd40);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        chk("abort_x", 128'(x_a), 128'd0);
        chk("abort_busy", 128'(busy_a), 128'd0);
        hits = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (valid_a || busy_a) hits++;
        end
        chk("abort_no_result", 128'(hits), 128'd0);
        run_a(1, tt_x6, 64, 1'b0);
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;

        // asynchronous reset at idx 90
        fsel_a  = 0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (n = 0; n < 300 && x_a !== 7'd90; n++) tick();
        chk("rst_reached_idx90", 128'(x_a), 128'd90);
        #2 rst = 1'b1;
        #1;
        chk("midrst_x", 128'(x_a), 128'd0);
        chk("midrst_busy", 128'(busy_a), 128'd0);
        chk("midrst_tt", tt_a, 128'd0);
        chk("midrst_valid", 128'(valid_a), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (valid_a || busy_a) hits++;
        end
        chk("midrst_no_result", 128'(hits), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/tt_sweep_capture.md
Name: tt_sweep_capture

Overview:
- Sequential companion to the 7-input majority-network function blocks. Those blocks map an input vector x0..x6 to a single output; this block goes the other way and recovers the function's 128-bit truth table.
- It sweeps all 128 input minterms into a function-under-test, waits a programmable settle time, samples the 1-bit response, and assembles the truth table.
- The finished table is presented on a valid/ready result port. It is used in the classification bench and in on-chip self-check of synthesized function blocks.

Parameters:
- SETTLE_CYCLES, 1, cycles x is held stable before func_out is sampled; legal range 0..255
- TT_BITS, 128, truth-table width; fixed at 2^7, not to be overridden

Ports:
- clk  input  1  single clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a sweep; accepted only in IDLE
- abort  input  1  synchronous abort of a running sweep
- x  output  7  stimulus to the function-under-test; x[0] drives x0 ... x[6] drives x6
- func_out  input  1  response of the function-under-test (combinational from x)
- busy  output  1  high in SETTLE and SAMPLE
- tt  output  128  truth table; tt[i] = f(x=i), with x0 as the LSB of i
- tt_valid  output  1  result valid; held until accepted
- tt_ready  input  1  consumer accepts the result when tt_valid && tt_ready at a rising edge

Behaviour:
- Reset (async, rst=1): state=IDLE, x=0, tt=0, tt_valid=0, busy=0, idx=0, settle counter=0; all optional outputs 0.
- States: IDLE, SETTLE, SAMPLE, RESULT.
- IDLE:
  - x=0.
  - start=1 at an edge: tt cleared to 0, idx=0, x=0, go to SETTLE (or directly to SAMPLE if SETTLE_CYCLES=0).
- SETTLE:
  - x=idx. Stays for exactly SETTLE_CYCLES cycles, then goes to SAMPLE.
- SAMPLE:
  - One cycle. x=idx; at the closing edge tt[idx] <= func_out.
  - If idx==127, go to RESULT. Otherwise idx <= idx+1, x follows, go to SETTLE (or SAMPLE when SETTLE_CYCLES=0).
- Timing:
  - Each minterm occupies SETTLE_CYCLES+1 cycles.
  - tt_valid rises exactly 128*(SETTLE_CYCLES+1) cycles after the start-accept edge (256 cycles at default).
- RESULT:
  - tt_valid=1, tt stable, x=0.
  - On tt_valid && tt_ready: tt_valid <= 0, go to IDLE. tt keeps its value until the next accepted start or reset.
- idx is 7 bits. There is no wrap-around: the sweep terminates at 127, never re-issues 0.
- Ignored inputs:
  - start outside IDLE, including in RESULT and together with tt_ready; the consumer must re-issue start once back in IDLE.
  - tt_ready outside RESULT.
- abort in SETTLE/SAMPLE: go to IDLE next edge, x=0, tt_valid stays 0, tt holds the partial table (undefined content).
- abort in IDLE/RESULT: ignored. abort has priority over the SAMPLE capture in the same cycle.
- Reset mid-sweep: immediate return to the reset values above; no result produced.

Optional Feature:
- Macro: TT_WEIGHT_EN.
- When defined:
  - Adds output tt_weight (8 bits), the number of ones in tt (0..128).
  - Built incrementally: cleared at start accept, incremented at each SAMPLE edge with func_out=1.
  - Valid whenever tt_valid=1; reset value 0; not cleared by abort.
- When undefined: port and counter absent; all other behaviour identical.

Test Plan:
- DUT f=x0, SETTLE_CYCLES=1, pulse start -> tt_valid after exactly 256 cycles, tt=0xAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA, tt_weight=64.
- DUT f=x6 -> tt=0xFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000. Hold tt_ready=0 for 10 cycles -> tt_valid and tt stay stable; tt_ready=1 -> IDLE next edge.
- DUT f=AND(x0..x6) with SETTLE_CYCLES=0 -> tt=0x8000_..._0000 (only bit 127 set), tt_valid after 128 cycles, tt_weight=1. DUT f=0 -> tt=0, tt_weight=0.
- Pulse start while busy, and start together with tt_ready in RESULT -> both ignored; a single result; state IDLE after the handshake.
- abort at idx=40 -> IDLE next edge, x=0, tt_valid never asserts. A new start then yields the correct full table.
- Assert rst at idx=90 (asynchronously, mid-cycle) -> x=0, busy=0, tt=0, tt_valid=0 immediately; no result after rst release.
